// File: rtl/i2c_master.sv
// Single-byte I2C bus master: START, 7-bit address, R/W, address ACK, one data byte,
// data ACK/NACK, STOP. There is no arbitration and no clock stretching.
// Each bit slot is four quarter phases of CLK_DIV clk cycles each.
module i2c_master #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       scl,
  inout  wire        sda
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    StIdle, StStart, StAddr, StRw, StAack, StWdata, StWack, StRdata, StRnack, StStop
  } state_e;

  state_e          r_state, w_state_next;
  logic [1:0]      r_q, w_q_next;
  logic [2:0]      r_bit, w_bit_next;
  logic [DivW-1:0] r_div;
  logic [7:0]      r_sh;       // outgoing bits, MSB on the bus
  logic [7:0]      r_wdata;
  logic [7:0]      r_rx;
  logic [7:0]      r_rdata;
  logic            r_rw, r_busy, r_done, r_ack_err;

  logic w_tick, w_accept, w_slot_end, w_scl, w_sda_low, w_sda_in;

  assign w_tick     = r_busy && (r_div == DivLast);
  assign w_accept   = start && !r_busy;
  assign w_slot_end = w_tick && (r_q == 2'd3);
  assign w_sda_in   = sda;

  // Next state and bus levels; bus levels depend only on state and quarter phase.
  always_comb begin
    w_state_next = r_state;
    w_q_next     = w_tick ? r_q + 2'd1 : r_q;
    w_bit_next   = r_bit;
    w_scl        = 1'b1;
    w_sda_low    = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_next = StStart;
          w_q_next     = 2'd0;
          w_bit_next   = 3'd0;
        end
      end
      StStart: begin
        w_sda_low = r_q[1];
        if (w_slot_end) w_state_next = StAddr;
      end
      StAddr: begin
        w_scl     = r_q[1];
        w_sda_low = !r_sh[7];
        if (w_slot_end) begin
          w_bit_next = r_bit + 3'd1;
          if (r_bit == 3'd6) begin
            w_state_next = StRw;
            w_bit_next   = 3'd0;
          end
        end
      end
      StRw: begin
        w_scl     = r_q[1];
        w_sda_low = !r_sh[7];
        if (w_slot_end) w_state_next = StAack;
      end
      StAack: begin
        w_scl = r_q[1];
        if (w_slot_end) begin
          if (w_sda_in)  w_state_next = StStop;
          else if (r_rw) w_state_next = StRdata;
          else           w_state_next = StWdata;
          w_bit_next = 3'd0;
        end
      end
      StWdata: begin
        w_scl     = r_q[1];
        w_sda_low = !r_sh[7];
        if (w_slot_end) begin
          w_bit_next = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_next = StWack;
        end
      end
      StWack: begin
        w_scl = r_q[1];
        if (w_slot_end) w_state_next = StStop;
      end
      StRdata: begin
        w_scl = r_q[1];
        if (w_slot_end) begin
          w_bit_next = r_bit + 3'd1;
          if (r_bit == 3'd7) w_state_next = StRnack;
        end
      end
      StRnack: begin
        w_scl = r_q[1];
        if (w_slot_end) w_state_next = StStop;
      end
      StStop: begin
        w_scl     = (r_q != 2'd0);
        w_sda_low = !r_q[1];
        if (w_slot_end) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_q     <= 2'd0;
      r_bit   <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_q     <= w_q_next;
      r_bit   <= w_bit_next;
    end
  end

  // Divider, transaction latches, shift registers and result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div     <= '0;
      r_sh      <= 8'h00;
      r_wdata   <= 8'h00;
      r_rx      <= 8'h00;
      r_rdata   <= 8'h00;
      r_rw      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_ack_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_busy    <= 1'b1;
        r_sh      <= {addr, rw};
        r_rw      <= rw;
        r_wdata   <= wdata;
        r_ack_err <= 1'b0;
        r_div     <= '0;
      end else if (r_busy) begin
        r_div <= w_tick ? '0 : r_div + DivW'(1);
      end
      if (w_slot_end) begin
        case (r_state)
          StAddr, StRw, StWdata: r_sh <= {r_sh[6:0], 1'b0};
          StAack: begin
            if (w_sda_in)   r_ack_err <= 1'b1;
            else if (!r_rw) r_sh      <= r_wdata;
          end
          StWack:  if (w_sda_in) r_ack_err <= 1'b1;
          StRdata: r_rx <= {r_rx[6:0], w_sda_in};
          StStop: begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
            if (r_rw && !r_ack_err) r_rdata <= r_rx;
          end
          default: ;
        endcase
      end
    end
  end

  assign scl     = w_scl;
  assign sda     = w_sda_low ? 1'b0 : 1'bz;
  assign rdata   = r_rdata;
  assign busy    = r_busy;
  assign done    = r_done;
  assign ack_err = r_ack_err;

endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master: a reactive slave on the bus, a slot-level model of
// the expected bus waveform and result flags, and directed plus random frames.
module tb_i2c_master;

  localparam int D = 4;
  localparam logic [6:0] SlvAddr = 7'h2A;
  localparam int FrameBound = 200 * D;
  localparam int RstAt = 13 * 4 * D + D + 1;  // inside WDATA slot 3, scl low

  logic       clk, rst, start, rw;
  logic [6:0] addr;
  logic [7:0] wdata;
  wire  [7:0] rdata;
  wire        busy, done, ack_err, scl;
  wire        sda;

  pullup (sda);

  i2c_master #(.CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .start(start), .addr(addr), .rw(rw), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .ack_err(ack_err), .scl(scl), .sda(sda)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] sq(input logic [7:0] x);
    logic [15:0] p;
    p = 16'(x) * 16'(x);
    return p[7:0];
  endfunction

  // Reactive slave at SlvAddr: stores a written byte, returns its byte on read and then
  // replaces it by its square (low 8 bits).
  logic       sl_drive = 1'b0;
  logic [7:0] sl_data = 8'h00;
  assign sda = sl_drive ? 1'b0 : 1'bz;

  initial begin : slave
    logic pscl, psda, bscl, bsda, active, match, rd;
    logic [7:0] sr, rx;
    int cnt;
    pscl = 1'b1; psda = 1'b1; active = 1'b0; match = 1'b0; rd = 1'b0;
    sr = 8'h00; rx = 8'h00; cnt = 0;
    forever begin
      @(negedge clk);
      bscl = scl;
      bsda = sda;
      if (pscl && bscl && psda && !bsda) begin
        active = 1'b1; cnt = 0; sl_drive = 1'b0;
      end else if (pscl && bscl && !psda && bsda) begin
        active = 1'b0; sl_drive = 1'b0;
      end else if (active && !pscl && bscl) begin
        cnt++;
        if (cnt <= 8) sr = {sr[6:0], bsda};
        else if (cnt >= 10 && cnt <= 17) rx = {rx[6:0], bsda};
      end else if (active && pscl && !bscl) begin
        sl_drive = 1'b0;
        if (cnt == 8) begin
          match = (sr[7:1] == SlvAddr);
          rd = sr[0];
          sl_drive = match;
        end else if (match && rd && cnt >= 9 && cnt <= 16) begin
          sl_drive = !sl_data[16-cnt];
        end else if (match && rd && cnt == 17) begin
          sl_data = sq(sl_data);
        end else if (match && !rd && cnt == 17) begin
          sl_data = rx;
          sl_drive = 1'b1;
        end
      end
      pscl = bscl;
      psda = bsda;
    end
  end

  // Transaction model: frame position k counts clk edges since accept.
  logic       m_in = 1'b0, m_done = 1'b0, m_ack_err = 1'b0, m_rw = 1'b0, m_match = 1'b0;
  logic [6:0] m_addr = 7'h00;
  logic [7:0] m_wdata = 8'h00, m_rdata = 8'h00, m_mem = 8'h00;
  int         m_k = 0, m_len = 0, m_nslots = 0, m_rises = 0;

  function automatic void exp_bus(input int k, output logic e_scl, output logic e_sda);
    int s, qq;
    s  = k / (4 * D);
    qq = (k % (4 * D)) / D;
    e_sda = 1'b1;
    if (s == 0) begin
      e_scl = 1'b1;
      e_sda = (qq < 2);
    end else if (s == m_nslots - 1) begin
      e_scl = (qq != 0);
      e_sda = (qq >= 2);
    end else begin
      e_scl = (qq >= 2);
      if (s <= 7)       e_sda = m_addr[7-s];
      else if (s == 8)  e_sda = m_rw;
      else if (s == 9)  e_sda = !m_match;
      else if (s <= 17) e_sda = m_rw ? m_mem[17-s] : m_wdata[17-s];
      else              e_sda = m_rw;
    end
  endfunction

  initial begin : compare
    logic e_scl, e_sda, p_scl, p_sda;
    int s;
    p_scl = 1'b1;
    p_sda = 1'b1;
    forever begin
      @(posedge clk);
      cyc++;
      m_done = 1'b0;
      if (rst) begin
        m_in = 1'b0; m_rdata = 8'h00; m_ack_err = 1'b0;
      end else if (m_in) begin
        m_k++;
        if (m_k == m_len) begin
          m_in = 1'b0;
          m_done = 1'b1;
          m_ack_err = !m_match;
          if (m_match && m_rw) begin
            m_rdata = m_mem;
            m_mem = sq(m_mem);
          end else if (m_match) begin
            m_mem = m_wdata;
          end
        end
      end else if (start) begin
        m_in = 1'b1; m_k = 0; m_addr = addr; m_rw = rw; m_wdata = wdata;
        m_match = (addr == SlvAddr);
        m_nslots = m_match ? 20 : 11;
        m_len = m_nslots * 4 * D;
        m_ack_err = 1'b0;
        m_rises = 0;
      end
      #1;
      chk("busy", 32'(busy), 32'(m_in));
      chk("done", 32'(done), 32'(m_done));
      chk("rdata", 32'(rdata), 32'(m_rdata));
      if (!m_in) begin
        chk("ack_err", 32'(ack_err), 32'(m_ack_err));
        chk("idle_scl", 32'(scl), 32'd1);
        chk("idle_sda", 32'(sda), 32'd1);
      end else begin
        exp_bus(m_k, e_scl, e_sda);
        chk("scl", 32'(scl), 32'(e_scl));
        if (e_scl) chk("sda", 32'(sda), 32'(e_sda));
      end
      if (!rst && m_in) begin
        s = m_k / (4 * D);
        if (!p_scl && scl) m_rises++;
        if (p_scl && scl && (p_sda !== sda))
          chk("sda_change_scl_high", 32'(s == 0 || s == m_nslots - 1), 32'd1);
        if (m_k == 40 * D - 1) chk("rises_before_aack", 32'(m_rises), 32'd9);
      end
      p_scl = scl;
      p_sda = sda;
    end
  end

  // Called at a negedge; returns at the negedge where done is seen (or after the reset).
  task automatic do_frame(input logic [6:0] a, input logic r, input logic [7:0] wd,
                          input int mode, output int len);
    int c0, i;
    bit got;
    start = 1'b1; addr = a; rw = r; wdata = wd;
    @(negedge clk);
    start = 1'b0;
    addr = 7'($urandom); rw = 1'($urandom); wdata = 8'($urandom);
    c0 = cyc; got = 1'b0; len = -1; i = 0;
    while (!got && i < FrameBound) begin
      if (done) begin
        got = 1'b1;
        len = cyc - c0;
      end else begin
        if (mode == 1 && i == 50) begin start = 1'b1; addr = ~a; end
        if (mode == 1 && i == 51) start = 1'b0;
        if (mode == 2 && i == RstAt) rst = 1'b1;
        if (mode == 2 && i == RstAt + 2) begin rst = 1'b0; got = 1'b1; end
        if (!got) begin
          @(negedge clk);
          i++;
        end
      end
    end
    if (!got) chk("frame_timeout", 32'(i), 32'(FrameBound + 1));
  endtask

  task automatic chk_len(input string name, input int len, input int exp);
    n_checks++;
    if (len < exp - 1 || len > exp + 1) begin
      n_fail++;
      $display("FAIL %s: got %0d cycles expected %0d +-1", name, len, exp);
    end
  endtask

  initial begin : stim
    int len;
    logic [6:0] ra;
    rst = 1'b1; start = 1'b0; addr = 7'h00; rw = 1'b0; wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_scl", 32'(scl), 32'd1);
    chk("rst_sda", 32'(sda), 32'd1);
    chk("rst_rdata", 32'(rdata), 32'h00);
    chk("rst_ack_err", 32'(ack_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_frame(7'h2A, 1'b0, 8'hA5, 0, len);
    chk_len("write_len", len, 80 * D);
    chk("write_ack_err", 32'(ack_err), 32'd0);
    chk("slave_data", 32'(sl_data), 32'hA5);

    do_frame(7'h2A, 1'b1, 8'h00, 0, len);
    chk("read1_rdata", 32'(rdata), 32'hA5);
    chk("read1_ack_err", 32'(ack_err), 32'd0);

    do_frame(7'h2A, 1'b1, 8'h00, 0, len);
    chk_len("read2_len", len, 80 * D);
    chk("read2_rdata", 32'(rdata), 32'h59);

    do_frame(7'h15, 1'b0, 8'h3C, 0, len);
    chk_len("nack_len", len, 44 * D);
    chk("nack_ack_err", 32'(ack_err), 32'd1);
    chk("nack_rdata", 32'(rdata), 32'h59);

    do_frame(7'h2A, 1'b0, 8'hC3, 1, len);
    chk_len("busy_start_len", len, 80 * D);
    chk("busy_start_slave", 32'(sl_data), 32'hC3);

    do_frame(7'h2A, 1'b0, 8'h77, 2, len);
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_done", 32'(done), 32'd0);
      chk("post_rst_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end
    chk("post_rst_rdata", 32'(rdata), 32'h00);
    chk("aborted_write_slave", 32'(sl_data), 32'hC3);

    do_frame(7'h2A, 1'b1, 8'h00, 0, len);
    chk("after_rst_rdata", 32'(rdata), 32'hC3);
    chk("after_rst_ack_err", 32'(ack_err), 32'd0);

    for (int n = 0; n < 24; n++) begin
      ra = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SlvAddr;
      do_frame(ra, 1'($urandom), 8'($urandom), 0, len);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Synchronous single-byte I2C bus master that generates SCL and drives SDA toward the team's i2c_slave.
- It is the upstream stage of that slave: a host issues one transaction with a start pulse. The master then runs START, 7-bit address, R/W bit, address ACK, one data byte, data ACK/NACK and STOP.
- It reports the read byte and ACK status. No multi-master arbitration and no clock stretching.

Parameters:
- CLK_DIV, 25, clk cycles per quarter SCL bit (legal range ≥1). One SCL bit = 4*CLK_DIV clk cycles.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse. Accepted only when busy=0.
- addr  input  7  target address, latched at accept.
- rw  input  1  0=write, 1=read, latched at accept.
- wdata  input  8  write byte, latched at accept.
- rdata  output  8  last byte read. Updated only at done of a read with ack_err=0.
- busy  output  1  high from the cycle after accept until done.
- done  output  1  one-cycle pulse at end of transaction.
- ack_err  output  1  result flag, valid from done until next accept.
- scl  output  1  bus clock, push-pull.
- sda  inout  1  open-drain style: driven 0 or released to Z. Never driven 1. Bench supplies a pullup.

Behaviour:
- Reset (async, immediate):
  - scl=1, sda released.
  - busy=0, done=0, ack_err=0, rdata=8'h00.
  - State IDLE, divider cleared.
- Divider: counter 0..CLK_DIV-1 runs only when busy. A tick fires on terminal count. Quarter phase q advances 0→1→2→3 on each tick.
- Accept: when start=1 and busy=0, latch addr/rw/wdata, clear ack_err, enter START. busy rises the next cycle. start while busy is ignored, with no latching.
- States: IDLE, START, ADDR, RW, AACK, WDATA, WACK, RDATA, RNACK, STOP.
- Data-bit slot, used by ADDR/RW/WDATA/RNACK and the master-released slots AACK/WACK/RDATA:
  - q0: scl=0, set sda (drive or release).
  - q1: scl=0.
  - q2: scl=1.
  - q3: scl=1; sample sda on the tick ending q3.
  - SDA never changes while scl=1 inside a data slot.
- START slot:
  - q0–q1: scl=1, sda released.
  - q2–q3: scl=1, sda=0 (falling SDA with SCL high).
- ADDR: 7 slots, addr[6] first. Then RW: 1 slot carrying the latched rw.
- AACK: sda released, sampled at q3.
  - 1 (NACK): ack_err=1, go to STOP.
  - 0: go to WDATA if rw=0, else RDATA.
- WDATA: 8 slots, MSB first. Then WACK: sample. NACK sets ack_err=1. Always go to STOP.
- RDATA: 8 slots, released, shift samples MSB first into a holding register. Then RNACK: sda released (master NACK, single byte). Then STOP.
- STOP slot:
  - q0: scl=0, sda=0.
  - q1: scl=1, sda=0.
  - q2–q3: scl=1, sda released (rising SDA with SCL high).
  - At the end of q3: done=1 for one cycle, busy=0, state IDLE.
  - For a read with ack_err=0, rdata loads the holding register in the same cycle.
- Frame length (start-accept cycle to done cycle):
  - Full transaction: 20 slots = 80*CLK_DIV clk cycles (±1 cycle).
  - Address NACK: 11 slots = 44*CLK_DIV.
- Idle bus: scl=1, sda released.
- A new start may be accepted in the cycle after done.
- Reset mid-frame: bus is released immediately. The spurious edge this may produce is allowed. Outputs take their reset values and no done is issued.

Test Plan:
- Write, CLK_DIV=4, i2c_slave my_addr=7'h2A. Issue start, addr=2A, rw=0, wdata=A5 -> done after 320±1 cycles, ack_err=0, slave curr_data=8'hA5, busy high throughout.
- Read following the write (same slave) -> rdata=8'hA5, ack_err=0, SDA released during 8 data slots and the RNACK slot.
- Second read -> rdata=8'h59 (slave squared A5), confirming back-to-back frames with start in the cycle after done.
- Wrong address addr=7'h15 -> ack_err=1, no data slots, done after 176±1 cycles, rdata unchanged.
- Protocol checker over all frames:
  - SDA stable whenever scl=1, except the START fall and STOP rise.
  - sda never driven 1.
  - Exactly 9 SCL rising edges before the address ACK sample.
- start pulsed while busy with different addr -> ignored, original frame unaffected. Assert rst during WDATA slot 3 -> scl=1, sda Z, busy=0, no done. The next start completes normally.
